// File: rtl/add_param_pkg.sv
// Shared constants and helpers for the add_param adder: carry-lookahead group
// width and the number of groups needed to cover an N-bit operand.
package add_param_pkg;

  localparam int GRP = 4;

  function automatic int ngroups(input int n);
    return (n + GRP - 1) / GRP;
  endfunction

endpackage

// File: rtl/add_param_cla4.sv
// 4-bit carry-lookahead group: sum bits, carry-out, and group generate/propagate
// so the parent can ripple or look ahead across groups.
module add_param_cla4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  output logic [3:0] s4,
  output logic       cout,
  output logic       g,
  output logic       p
);

  logic [3:0] gen_b;
  logic [3:0] prp_b;
  logic [3:0] c_in_b;

  assign gen_b = a4 & b4;
  assign prp_b = a4 ^ b4;

  // Carry into each bit position, fully expanded from cin.
  assign c_in_b[0] = cin;
  assign c_in_b[1] = gen_b[0] | (prp_b[0] & cin);
  assign c_in_b[2] = gen_b[1] | (prp_b[1] & gen_b[0]) | (prp_b[1] & prp_b[0] & cin);
  assign c_in_b[3] = gen_b[2] | (prp_b[2] & gen_b[1]) | (prp_b[2] & prp_b[1] & gen_b[0])
                   | (prp_b[2] & prp_b[1] & prp_b[0] & cin);

  assign s4 = prp_b ^ c_in_b;

  assign g = gen_b[3] | (prp_b[3] & gen_b[2]) | (prp_b[3] & prp_b[2] & gen_b[1])
           | (prp_b[3] & prp_b[2] & prp_b[1] & gen_b[0]);
  assign p = &prp_b;

  assign cout = g | (p & cin);

endmodule

// File: rtl/add_param.sv
// Width-parameterised two-operand adder with carry/overflow flags, optional
// unsigned saturation, and a 1-cycle registered copy of sum and flags.
module add_param
  import add_param_pkg::*;
#(
  parameter int N   = 16,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         en,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] y_q,
  output logic         cout_q,
  output logic         ovf_q
);

  localparam int  NG     = ngroups(N);
  localparam int  W      = NG * GRP;
  localparam bit  SAT_EN = (SAT != 0);

  logic [W-1:0]  a_pad;
  logic [W-1:0]  b_pad;
  logic [W-1:0]  sum_pad;
  logic [NG:0]   carry;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [W:0]    raw_ext;
  logic [N-1:0]  s_raw;
  logic          c_raw;
  logic [N-1:0]  y_d;
  logic          cout_d;
  logic          ovf_d;
  logic          unused_bits;

  always_comb begin
    a_pad        = '0;
    b_pad        = '0;
    a_pad[N-1:0] = a;
    b_pad[N-1:0] = b;
  end

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    add_param_cla4 u_cla4 (
      .a4   (a_pad[i*GRP +: GRP]),
      .b4   (b_pad[i*GRP +: GRP]),
      .cin  (carry[i]),
      .s4   (sum_pad[i*GRP +: GRP]),
      .cout (carry[i+1]),
      .g    (grp_g[i]),
      .p    (grp_p[i])
    );
  end

  // Padding bits are zero, so bit N of the padded sum is the true carry-out.
  assign raw_ext = {carry[NG], sum_pad};
  assign s_raw   = raw_ext[N-1:0];
  assign c_raw   = raw_ext[N];

  assign unused_bits = ^{raw_ext, grp_g, grp_p};

  assign y_d    = (SAT_EN && c_raw) ? {N{1'b1}} : s_raw;
  assign cout_d = c_raw;
  assign ovf_d  = (a[N-1] == b[N-1]) && (s_raw[N-1] != a[N-1]);

  assign y    = y_d;
  assign cout = cout_d;
  assign ovf  = ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      y_q    <= y_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_add_param.sv
// Bench for add_param: directed vectors on 16-bit wrap/saturating, 1-bit and
// 5-bit instances plus a 256-deep combinational prefix-sum chain.
module tb_add_param;

  logic clk;
  logic rst;
  logic en;
  logic [15:0] a, b;
  logic a1, b1;
  logic [4:0] a5, b5;
  logic [15:0] cx;
  logic obs_stb;

  logic [15:0] y0, yq0, ys, ysq;
  logic c0, o0, cq0, oq0, cs1, os1, csq, osq;
  logic y1, c1, o1, yq1, cq1, oq1;
  logic [4:0] y5, yq5;
  logic c5, o5, cq5, oq5;

  logic [15:0] ca [256];
  logic [15:0] cs [256];
  logic [15:0] csq_a [256];
  logic cc [256], co [256], ccq [256], coq [256];

  logic [31:0] exp_q[$];
  int total;
  int bad;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1);
  end

  add_param #(.N(16), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(y0), .cout(c0), .ovf(o0), .y_q(yq0), .cout_q(cq0), .ovf_q(oq0)
  );

  add_param #(.N(16), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .y(ys), .cout(cs1), .ovf(os1), .y_q(ysq), .cout_q(csq), .ovf_q(osq)
  );

  add_param #(.N(1), .SAT(0)) u_n1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en),
    .y(y1), .cout(c1), .ovf(o1), .y_q(yq1), .cout_q(cq1), .ovf_q(oq1)
  );

  add_param #(.N(5), .SAT(0)) u_n5 (
    .clk(clk), .rst(rst), .a(a5), .b(b5), .en(en),
    .y(y5), .cout(c5), .ovf(o5), .y_q(yq5), .cout_q(cq5), .ovf_q(oq5)
  );

  for (genvar k = 0; k < 256; k++) begin : g_chain
    if (k == 0) begin : g_first
      assign ca[k] = cx;
    end else begin : g_rest
      assign ca[k] = cs[k-1];
    end
    add_param #(.N(16), .SAT(0)) u_acc (
      .clk(clk), .rst(rst), .a(ca[k]), .b(cx), .en(en),
      .y(cs[k]), .cout(cc[k]), .ovf(co[k]),
      .y_q(csq_a[k]), .cout_q(ccq[k]), .ovf_q(coq[k])
    );
  end

  function automatic string kname(input int k);
    case (k)
      0: return "wrap_comb";
      1: return "wrap_reg";
      2: return "sat_comb";
      3: return "sat_reg";
      4: return "n1_comb";
      5: return "n5_comb";
      6: return "chain_sum";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] pk(input int kind, input int idx,
                                     input logic [15:0] ey, input logic ec, input logic eo);
    logic [3:0] kd;
    logic [9:0] ix;
    kd = kind[3:0];
    ix = idx[9:0];
    return {kd, ix, ey, ec, eo};
  endfunction

  // driver tasks
  task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic env);
    @(negedge clk);
    a  = av;
    b  = bv;
    en = env;
  endtask

  task automatic chk(input int kind, input int idx, input logic [15:0] ey,
                     input logic ec, input logic eo);
    #1;
    exp_q.push_back(pk(kind, idx, ey, ec, eo));
    obs_stb = 1'b1;
    #1;
    obs_stb = 1'b0;
  endtask

  // scoreboard monitor
  always @(posedge obs_stb) begin
    logic [31:0] e;
    int kd, ix;
    logic [15:0] gy;
    logic gc, go;
    logic mism;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got observation with empty queue, required queued expectation");
    end else begin
      e  = exp_q.pop_front();
      kd = int'(e[31:28]);
      ix = int'(e[27:18]);
      gy = '0;
      gc = 1'b0;
      go = 1'b0;
      case (kd)
        0: begin gy = y0;  gc = c0;  go = o0;  end
        1: begin gy = yq0; gc = cq0; go = oq0; end
        2: begin gy = ys;  gc = cs1; go = os1; end
        3: begin gy = ysq; gc = csq; go = osq; end
        4: begin gy = {15'b0, y1}; gc = c1; go = o1; end
        5: begin gy = {11'b0, y5}; gc = c5; go = o5; end
        default: begin gy = cs[ix]; end
      endcase
      if (kd == 6) mism = (gy !== e[17:2]);
      else         mism = ({gy, gc, go} !== e[17:0]);
      if (mism) begin
        bad++;
        $display("FAIL %s[%0d]: got y=%h c=%b o=%b, required y=%h c=%b o=%b",
                 kname(kd), ix, gy, gc, go, e[17:2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic [1:0]  n1v;
    logic [15:0] ev;
    logic [4:0]  n5a [4];
    logic [4:0]  n5b [4];
    logic [4:0]  n5y [4];
    logic        n5c [4];
    logic        n5o [4];
    logic [15:0] tv_a [3];
    logic [15:0] tv_b [3];
    logic [15:0] tv_y [3];
    logic        tv_c [3];
    logic        tv_o [3];

    total = 0;
    bad = 0;
    obs_stb = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    a = '0; b = '0; a1 = 1'b0; b1 = 1'b0; a5 = '0; b5 = '0; cx = '0;

    // reset state and 0+0
    @(negedge clk);
    chk(1, 0, 16'h0000, 1'b0, 1'b0);
    chk(3, 0, 16'h0000, 1'b0, 1'b0);
    chk(0, 0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // basic add and 1-cycle registered latency
    drive(16'h0003, 16'h0004, 1'b1);
    chk(0, 1, 16'h0007, 1'b0, 1'b0);
    @(negedge clk);
    chk(1, 1, 16'h0007, 1'b0, 1'b0);

    // all-ones + 1: wrap vs saturate
    drive(16'hFFFF, 16'h0001, 1'b1);
    chk(0, 2, 16'h0000, 1'b1, 1'b0);
    chk(2, 2, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    chk(1, 2, 16'h0000, 1'b1, 1'b0);
    chk(3, 2, 16'hFFFF, 1'b1, 1'b0);

    // signed overflow cases
    drive(16'h7FFF, 16'h0001, 1'b1);
    chk(0, 3, 16'h8000, 1'b0, 1'b1);
    chk(2, 3, 16'h8000, 1'b0, 1'b1);
    drive(16'h8000, 16'h8000, 1'b1);
    chk(0, 4, 16'h0000, 1'b1, 1'b1);
    chk(2, 4, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    chk(1, 4, 16'h0000, 1'b1, 1'b1);
    chk(3, 4, 16'hFFFF, 1'b1, 1'b1);

    // load 1234 then hold with en=0 while operands change
    drive(16'h1000, 16'h0234, 1'b1);
    chk(0, 5, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    chk(1, 5, 16'h1234, 1'b0, 1'b0);
    tv_a = '{16'h0001, 16'hFFFF, 16'h4000};
    tv_b = '{16'h0001, 16'hFFFF, 16'h4000};
    tv_y = '{16'h0002, 16'hFFFE, 16'h8000};
    tv_c = '{1'b0, 1'b1, 1'b0};
    tv_o = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(tv_a[i], tv_b[i], 1'b0);
      chk(0, 6 + i, tv_y[i], tv_c[i], tv_o[i]);
      @(negedge clk);
      chk(1, 6 + i, 16'h1234, 1'b0, 1'b0);
    end

    // async reset mid-cycle with en=1, reset wins at the edge
    drive(16'h0005, 16'h0006, 1'b1);
    rst = 1'b1;
    chk(1, 9, 16'h0000, 1'b0, 1'b0);
    chk(3, 9, 16'h0000, 1'b0, 1'b0);
    chk(0, 9, 16'h000B, 1'b0, 1'b0);
    @(negedge clk);
    chk(1, 10, 16'h0000, 1'b0, 1'b0);
    chk(3, 10, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk(1, 11, 16'h000B, 1'b0, 1'b0);
    chk(3, 11, 16'h000B, 1'b0, 1'b0);

    // N=1 full-adder truth table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n1v = 2'(i);
      a1 = n1v[1];
      b1 = n1v[0];
      case (i)
        0: chk(4, i, 16'h0000, 1'b0, 1'b0);
        1: chk(4, i, 16'h0001, 1'b0, 1'b0);
        2: chk(4, i, 16'h0001, 1'b0, 1'b0);
        default: chk(4, i, 16'h0000, 1'b1, 1'b1);
      endcase
    end

    // N=5: padded group bits must not leak into y or cout
    n5a = '{5'h1F, 5'h10, 5'h0F, 5'h0A};
    n5b = '{5'h01, 5'h10, 5'h01, 5'h05};
    n5y = '{5'h00, 5'h00, 5'h10, 5'h0F};
    n5c = '{1'b1, 1'b1, 1'b0, 1'b0};
    n5o = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a5 = n5a[i];
      b5 = n5b[i];
      chk(5, i, {11'b0, n5y[i]}, n5c[i], n5o[i]);
    end

    // prefix-sum chain: unit terms, then 0x100 terms wrapping at the 256th
    @(negedge clk);
    cx = 16'h0001;
    for (int k = 0; k < 256; k++) begin
      if (k % 4 == 0) @(negedge clk);
      ev = 16'(k + 2);
      chk(6, k, ev, 1'b0, 1'b0);
    end
    @(negedge clk);
    cx = 16'h0100;
    for (int k = 0; k < 256; k++) begin
      if (k % 4 == 0) @(negedge clk);
      ev = 16'((k + 2) * 256);
      chk(6, k, ev, 1'b0, 1'b0);
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
